instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of the multicycle control unit.
- Owns the program counter and the instruction register, and runs the instruction-memory read handshake with wait states and timeout.
- Exposes the latched instruction, its opcode field (Op) and decoded register fields to the control unit.
- Reports misaligned-PC and memory-timeout faults.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, max WAIT cycles before a fetch is aborted (range 1..255).
- NOP_INSTR, 32'h0000_0013, IR value after reset (addi x0,x0,0).

Ports:
- clock  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_start  in  1  control unit requests the next instruction.
- instr_ack  in  1  control unit has consumed the held instruction.
- pc_load  in  1  redirect the PC (branch/jump).
- pc_next  in  32  redirect target.
- mem_addr  out  32  instruction memory address.
- mem_rd  out  1  instruction memory read request.
- mem_rdata  in  32  instruction memory read data.
- mem_ready  in  1  mem_rdata valid this cycle.
- PC  out  32  next fetch address.
- PC_instr  out  32  address of the instruction held in IR.
- Instr  out  32  instruction register.
- Op  out  7  Instr[6:0].
- rd  out  5  Instr[11:7].
- funct3  out  3  Instr[14:12].
- rs1  out  5  Instr[19:15].
- rs2  out  5  Instr[24:20].
- funct7  out  7  Instr[31:25].
- instr_valid  out  1  Instr holds a fresh, unconsumed instruction.
- fault  out  1  sticky fetch fault.
- fault_code  out  2  0 none, 1 misaligned PC, 2 timeout.

Behaviour:
- Reset (clock edge with reset=1; overrides everything, including mid-fetch):
  - state=IDLE, PC=RESET_PC, PC_instr=RESET_PC, Instr=NOP_INSTR (so Op=7'h13).
  - instr_valid=0, mem_rd=0, mem_addr=RESET_PC, fault=0, fault_code=0, wait counter=0, pending redirect cleared.
- All outputs are registered. Field outputs are pure slices of Instr.
- States: IDLE, WAIT, HOLD.
- IDLE:
  - pc_load=1: PC<=pc_next, fault and fault_code cleared, fetch_start ignored this cycle.
  - Else fetch_start=1 with fault=0:
    - PC[1:0]!=0: fault<=1, fault_code<=1, stay IDLE.
    - Otherwise: mem_addr<=PC, mem_rd<=1, counter<=0, go WAIT.
  - fetch_start while fault=1: ignored.
- WAIT:
  - mem_rd and mem_addr are held stable.
  - mem_ready=1:
    - Instr<=mem_rdata, PC_instr<=mem_addr, instr_valid<=1, mem_rd<=0, go HOLD.
    - PC<=pending target if a redirect is pending (pending cleared), else mem_addr+4 (mod 2^32, wraps).
  - Else, counter reaching TIMEOUT-1: mem_rd<=0, fault<=1, fault_code<=2, go IDLE. PC and Instr unchanged.
  - Else counter increments.
  - pc_load in WAIT: pc_next stored as pending; the outstanding read is not cancelled. A later pc_load overwrites the pending value. On timeout the pending target is written to PC.
- HOLD:
  - instr_valid=1 and Instr is stable.
  - instr_ack=1: instr_valid<=0.
    - fetch_start=1 in the same cycle: a back-to-back fetch starts (same alignment check), going WAIT.
    - Otherwise go IDLE.
  - fetch_start without instr_ack: ignored.
  - pc_load in HOLD: PC<=pc_next immediately, Instr unaffected.
  - pc_load together with ack+fetch_start: redirect wins, the fetch is not started, go IDLE.
- Latency:
  - fetch_start sampled at edge N: mem_rd=1 after edge N.
  - mem_ready sampled at edge M: instr_valid=1 and Instr updated after edge M.
  - Minimum fetch_start to instr_valid is 2 edges (zero-wait memory).
- mem_ready outside WAIT is ignored.

Test Plan:
- Reset, then fetch_start for one cycle; memory returns 32'h00A00093 with 0 wait states -> mem_addr=0, instr_valid high 2 edges after fetch_start, Op=7'h13, rd=1, rs1=0, PC=4, PC_instr=0.
- Memory with 3 wait states, Instr 32'h002081B3 -> mem_rd high exactly 4 cycles with mem_addr stable, then Op=7'h33, rd=3, rs1=1, rs2=2, funct7=0.
- Set TIMEOUT=4 and never assert mem_ready -> after 4 WAIT cycles mem_rd=0, fault=1, fault_code=2, PC unchanged. A later pc_load to 32'h100 clears fault, and the next fetch reads address 32'h100.
- pc_load with pc_next=32'h102, then fetch_start -> no mem_rd, fault=1, fault_code=1.
- pc_load to 32'h40 during WAIT on address 32'h8 -> the read completes with PC_instr=32'h8 and PC=32'h40, not 32'hC.
- In HOLD, assert instr_ack+fetch_start together -> instr_valid drops and mem_rd rises on the same edge for PC+4. Separately, PC=32'hFFFFFFFC fetch -> PC wraps to 0. Assert reset in WAIT -> all outputs at their reset values on the next edge.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns PC and IR and runs the instruction-memory read handshake.
// A fetch is aborted if the memory stalls too long, and misaligned PCs are faulted.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          TIMEOUT   = 16,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic        instr_ack,
    input  logic        pc_load,
    input  logic [31:0] pc_next,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic [31:0] PC,
    output logic [31:0] PC_instr,
    output logic [31:0] Instr,
    output logic [6:0]  Op,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic        instr_valid,
    output logic        fault,
    output logic [1:0]  fault_code
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_instr_q, pc_instr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] addr_q, addr_d;
    logic        rd_q, rd_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [1:0]  code_q, code_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    // A redirect arriving in the same cycle as completion/timeout is the newest target.
    logic        tgt_valid;
    logic [31:0] tgt_pc;
    assign tgt_valid = pc_load | pend_q;
    assign tgt_pc    = pc_load ? pc_next : pend_pc_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pc_instr_q <= RESET_PC;
            instr_q    <= NOP_INSTR;
            addr_q     <= RESET_PC;
            rd_q       <= 1'b0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            code_q     <= 2'd0;
            cnt_q      <= 8'd0;
            pend_q     <= 1'b0;
            pend_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_instr_q <= pc_instr_d;
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_instr_d = pc_instr_q;
        instr_d    = instr_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;

        case (state_q)
            S_IDLE: begin
                if (pc_load) begin
                    pc_d    = pc_next;
                    fault_d = 1'b0;
                    code_d  = 2'd0;
                end else if (fetch_start && !fault_q) begin
                    if (pc_q[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        code_d  = 2'd1;
                    end else begin
                        addr_d  = pc_q;
                        rd_d    = 1'b1;
                        cnt_d   = 8'd0;
                        state_d = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (pc_load) begin
                    pend_d    = 1'b1;
                    pend_pc_d = pc_next;
                end
                if (mem_ready) begin
                    instr_d    = mem_rdata;
                    pc_instr_d = addr_q;
                    valid_d    = 1'b1;
                    rd_d       = 1'b0;
                    pc_d       = tgt_valid ? tgt_pc : addr_q + 32'd4;
                    pend_d     = 1'b0;
                    state_d    = S_HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    rd_d    = 1'b0;
                    fault_d = 1'b1;
                    code_d  = 2'd2;
                    if (tgt_valid) begin
                        pc_d = tgt_pc;
                    end
                    pend_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_HOLD: begin
                if (pc_load) begin
                    pc_d = pc_next;
                    if (instr_ack) begin
                        valid_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (instr_ack) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                    if (fetch_start) begin
                        if (pc_q[1:0] != 2'b00) begin
                            fault_d = 1'b1;
                            code_d  = 2'd1;
                        end else begin
                            addr_d  = pc_q;
                            rd_d    = 1'b1;
                            cnt_d   = 8'd0;
                            state_d = S_WAIT;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_addr    = addr_q;
        mem_rd      = rd_q;
        PC          = pc_q;
        PC_instr    = pc_instr_q;
        Instr       = instr_q;
        Op          = instr_q[6:0];
        rd          = instr_q[11:7];
        funct3      = instr_q[14:12];
        rs1         = instr_q[19:15];
        rs2         = instr_q[24:20];
        funct7      = instr_q[31:25];
        instr_valid = valid_q;
        fault       = fault_q;
        fault_code  = code_q;
    end

endmodule
